// File: rtl/inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// inst_prefetch_queue
//
// Instruction-fetch front end placed directly ahead of the IF stage. It fetches
// sequential instruction words from a variable-latency instruction memory and
// holds them in a small FIFO, each word stored with its PC. The head entry is
// presented to the IF/ID register. A redirect (taken branch or jump) flushes
// every buffered word and any word still in flight, then fetching restarts at
// the redirect target.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset (0 = reset)
//   redirect       taken branch/jump this cycle
//   redirect_addr  new fetch target, valid while redirect=1
//   deq            IF/ID consumes the head entry
//   inst_valid     head entry present
//   inst           head instruction word
//   inst_pc        PC of the head instruction
//   pc_plus4       inst_pc + 4
//   count          current FIFO occupancy
//   mem_req        one-cycle fetch request strobe
//   mem_addr       fetch address (always equal to the fetch PC)
//   mem_rsp_valid  one-cycle response strobe from memory
//   mem_rsp_data   returned instruction word
// -----------------------------------------------------------------------------
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [31:0]                redirect_addr,
  input  logic                       deq,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  output logic [31:0]                pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  input  logic                       mem_rsp_valid,
  input  logic [31:0]                mem_rsp_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     inst_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];

  logic            push;
  logic            pop;
  logic            not_empty;

  assign not_empty = (count_q != '0);

  // A request reserves the slot its response will fill, so a push can never
  // find the FIFO full. Gating with rst keeps the strobe low while in reset.
  assign mem_req  = rst & (state_q == IDLE) & (count_q < DEPTH_C) & ~redirect;
  assign mem_addr = fetch_pc_q;

  // Only a response to a live (non-discarded) request is stored, and a
  // redirect in the same cycle kills it as well.
  assign push = (state_q == WAIT) & mem_rsp_valid & ~redirect;
  // Redirect flushes the FIFO, so it overrides any dequeue.
  assign pop  = deq & not_empty & ~redirect;

  // Head outputs are forced to zero when empty so that reset shows all-zero.
  assign inst_valid = not_empty;
  assign count      = count_q;
  assign inst       = not_empty ? inst_mem[rd_ptr_q] : 32'h0;
  assign inst_pc    = not_empty ? pc_mem[rd_ptr_q]   : 32'h0;
  assign pc_plus4   = not_empty ? (pc_mem[rd_ptr_q] + 32'd4) : 32'h0;

  // Storage carries no reset: its contents are only visible through
  // entries counted in count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= mem_rsp_data;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_addr;
        end else if (mem_req) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
          if (redirect) begin
            fetch_pc_d = redirect_addr;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect) begin
          // The in-flight word belongs to the old path; drop it on arrival.
          fetch_pc_d = redirect_addr;
          state_d    = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
        end
        if (redirect) begin
          fetch_pc_d = redirect_addr;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_prefetch_queue
//
// Drives inst_prefetch_queue with a variable-latency memory model and compares
// every cycle against a transaction-level reference: a queue of {pc, inst}
// entries, the expected fetch PC, and an epoch number that marks which
// outstanding request belongs to the current fetch path.
// -----------------------------------------------------------------------------
module tb_inst_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XOR_K    = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        deq;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic [2:0]  count;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .deq          (deq),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .pc_plus4     (pc_plus4),
    .count        (count),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  // Reference state
  ent_t        q[$];
  logic [31:0] fpc;
  int          epoch;
  // Memory state (one outstanding request)
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_ep;
  int          pend_left;
  int          lat_min;
  int          lat_max;
  bit          spur_en;

  int tests;
  int fails;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, advance the model.
  task automatic step(input bit redir, input logic [31:0] raddr, input bit dq);
    bit   rsp_real;
    bit   exp_req;
    bit   acc;
    bit   req;
    ent_t e;
    @(negedge clk);
    rsp_real      = pend && (pend_left == 0);
    redirect      = redir;
    redirect_addr = raddr;
    deq           = dq;
    if (rsp_real) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = pend_addr ^ XOR_K;
    end else if (spur_en && !pend && $urandom_range(0, 9) == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    #1;
    exp_req = !pend && (q.size() < DEPTH) && !redir;
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    chk("mem_addr", mem_addr, fpc);
    chk("count", 32'(count), 32'(q.size()));
    chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("inst", inst, q[0].ins);
      chk("inst_pc", inst_pc, q[0].pc);
      chk("pc_plus4", pc_plus4, q[0].pc + 32'd4);
    end
    req = mem_req;
    acc = rsp_real && (pend_ep == epoch) && !redir;
    if (dq && q.size() != 0 && !redir) void'(q.pop_front());
    if (acc) begin
      e.pc  = fpc;
      e.ins = mem_rsp_data;
      q.push_back(e);
    end
    if (redir) begin
      q.delete();
      fpc = raddr;
      epoch++;
    end else if (acc) begin
      fpc = fpc + 32'd4;
    end
    if (rsp_real) pend = 1'b0;
    else if (pend) pend_left--;
    if (req) begin
      pend      = 1'b1;
      pend_addr = mem_addr;
      pend_ep   = epoch;
      pend_left = $urandom_range(lat_min, lat_max) - 1;
    end
  endtask

  // Assert reset just after a clock edge, check the asynchronous effect,
  // then release it away from any edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst           = 1'b0;
    redirect      = 1'b0;
    deq           = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_inst", inst, 32'd0);
    q.delete();
    fpc  = RESET_PC;
    pend = 1'b0;
    epoch++;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    bit          found;
    bit          r;
    logic [31:0] a;
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    redirect      = 1'b0;
    redirect_addr = 32'h0;
    deq           = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    fpc           = RESET_PC;
    epoch         = 0;
    pend          = 1'b0;
    pend_addr     = 32'h0;
    pend_ep       = 0;
    pend_left     = 0;
    lat_min       = 1;
    lat_max       = 1;
    spur_en       = 1'b0;

    // Power-on reset
    #2;
    rst = 1'b0;
    #1;
    chk("por_inst_valid", 32'(inst_valid), 32'd0);
    chk("por_count", 32'(count), 32'd0);
    chk("por_mem_req", 32'(mem_req), 32'd0);
    chk("por_mem_addr", mem_addr, RESET_PC);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // 1: fill with a 1-cycle memory, no dequeue
    repeat (12) step(1'b0, 32'h0, 1'b0);
    chk("p1_count", 32'(count), 32'd4);
    chk("p1_inst", inst, 32'hA5A5_0000);
    chk("p1_inst_pc", inst_pc, 32'h0);
    chk("p1_pc_plus4", pc_plus4, 32'h4);
    chk("p1_mem_req", 32'(mem_req), 32'd0);

    // 2: single dequeue frees one slot, refill from address 16
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk("p2_mem_addr", mem_addr, 32'd16);
    chk("p2_mem_req", 32'(mem_req), 32'd1);
    repeat (4) step(1'b0, 32'h0, 1'b0);
    chk("p2_count", 32'(count), 32'd4);

    // 3: redirect while waiting on a 3-cycle memory
    lat_min = 3;
    lat_max = 3;
    repeat (2) step(1'b0, 32'h0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend && pend_left > 0) found = 1'b1;
      else step(1'b0, 32'h0, 1'b0);
    end
    chk("p3_wait_req", 32'(found), 32'd1);
    step(1'b1, 32'h0000_0100, 1'b0);
    repeat (14) step(1'b0, 32'h0, 1'b0);
    chk("p3_inst_pc", inst_pc, 32'h100);

    // 4: redirect coinciding with a response and a dequeue
    lat_min = 2;
    lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend && pend_left == 0 && q.size() != 0) found = 1'b1;
      else step(1'b0, 32'h0, 1'b0);
    end
    chk("p4_wait_rsp", 32'(found), 32'd1);
    step(1'b1, 32'h0000_0200, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'($urandom_range(0, 1)));

    // 5: reset while waiting with two entries queued
    lat_min = 3;
    lat_max = 3;
    step(1'b1, 32'h0000_0300, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pend && q.size() == 2) found = 1'b1;
      else step(1'b0, 32'h0, 1'b0);
    end
    chk("p5_two_queued", 32'(found), 32'd1);
    do_reset();
    lat_min = 1;
    lat_max = 1;
    repeat (6) step(1'b0, 32'h0, 1'b0);

    // 6: fetch PC wraps through zero
    step(1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b0);
    chk("p6_inst_pc", inst_pc, 32'hFFFF_FFF8);
    repeat (12) step(1'b0, 32'h0, 1'($urandom_range(0, 1)));

    // 7: randomized traffic
    lat_min = 1;
    lat_max = 4;
    spur_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0:       a = $urandom & 32'hFFFF_FFFC;
        1:       a = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
        default: a = $urandom & 32'h0000_0FFC;
      endcase
      step(r, a, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
